// File: rtl/rat_io_pkg.sv
// Shared definitions for the MCU-mapped I/O ports: port IDs, transmitter
// state encoding, status bit positions and FIFO geometry.
package rat_io_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned FIFO_DEPTH    = 4;
    localparam int unsigned FIFO_PTR_W    = 2;
    localparam int unsigned FIFO_CNT_W    = 3;
    localparam int unsigned BITS_PER_CHAR = 8;
    localparam int unsigned BIT_IDX_W     = 3;

    localparam logic [BYTE_W-1:0] UART_DATA_ID   = 8'h50;
    localparam logic [BYTE_W-1:0] UART_STATUS_ID = 8'h51;

    // Status byte layout: {4'b0, ovf, busy, empty, full}
    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/byte_fifo4.sv
// 4-entry byte FIFO with registered full/empty flags and occupancy count.
// Ports: clk/rst_n, i_push/i_data write side, i_pop read side,
//        o_head_c (combinational head byte), o_full, o_empty, o_count.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo4
    import rat_io_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [BYTE_W-1:0]     i_data,
    input  logic                  i_pop,
    output logic [BYTE_W-1:0]     o_head_c,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [BYTE_W-1:0]     r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [FIFO_CNT_W-1:0] w_count_next;

    assign w_pop_ok  = i_pop & ~r_empty;
    assign w_push_ok = i_push & (~r_full | w_pop_ok);

    // Occupancy after this cycle's push/pop
    always_comb begin : count_next
        w_count_next = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_next = r_count + FIFO_CNT_W'(1);
        end else if (w_pop_ok && !w_push_ok) begin
            w_count_next = r_count - FIFO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == FIFO_CNT_W'(FIFO_DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin : mem_write
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_count  = r_count;

endmodule

// File: rtl/port_uart_tx.sv
// MCU port-mapped UART transmitter (8N1, LSB first, idle high).
// Ports: CLK/RESET_N; PORT_ID, OUT_PORT, IO_STRB from the MCU;
//        RD_DATA status read (combinational); TX serial line; INTR one-cycle
//        "transmitter drained" pulse.
// Writes to DATA_ID queue a byte; writes to STATUS_ID clear the sticky overflow.
module port_uart_tx
    import rat_io_pkg::*;
#(
    parameter logic [7:0]  DATA_ID      = UART_DATA_ID,
    parameter logic [7:0]  STATUS_ID    = UART_STATUS_ID,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  PORT_ID,
    input  logic [7:0]  OUT_PORT,
    input  logic        IO_STRB,
    output logic [7:0]  RD_DATA,
    output logic        TX,
    output logic        INTR
);

    localparam int unsigned          BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(BITS_PER_CHAR - 1);

    uart_state_e            r_state;
    logic [BAUD_W-1:0]      r_baud;
    logic [BIT_IDX_W-1:0]   r_bit_idx;
    logic [BYTE_W-1:0]      r_shift;
    logic                   r_tx;
    logic                   r_intr;
    logic                   r_strb_d;
    logic                   r_armed;
    logic                   r_ovf;

    uart_state_e            w_state_next;
    logic [BAUD_W-1:0]      w_baud_next;
    logic [BIT_IDX_W-1:0]   w_idx_next;
    logic [BYTE_W-1:0]      w_shift_next;
    logic                   w_tx_next;
    logic                   w_intr_next;
    logic                   w_pop;
    logic                   w_baud_end;
    logic                   w_write;
    logic                   w_data_wr;
    logic                   w_stat_wr;
    logic                   w_drop;
    logic [BYTE_W-1:0]      w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [FIFO_CNT_W-1:0]  w_unused_count;

    // r_armed blocks a write on the first edge after reset release
    assign w_write   = IO_STRB & ~r_strb_d & r_armed;
    assign w_data_wr = w_write & (PORT_ID == DATA_ID);
    assign w_stat_wr = w_write & (PORT_ID == STATUS_ID);
    assign w_drop    = w_data_wr & w_full & ~w_pop;
    assign w_baud_end = (r_baud == BAUD_LAST);

    byte_fifo4 u_fifo (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .i_push   (w_data_wr),
        .i_data   (OUT_PORT),
        .i_pop    (w_pop),
        .o_head_c (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_unused_count)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin : state_reg
        if (!RESET_N) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next state, bit timing and the registered line level for the next cycle
    always_comb begin : fsm_next
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_intr_next  = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                w_idx_next  = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == IDX_LAST) w_state_next = ST_STOP;
                    else                       w_idx_next   = r_bit_idx + BIT_IDX_W'(1);
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = ST_IDLE;
                    w_intr_next  = w_empty;
                end else begin
                    w_baud_next = r_baud + BAUD_W'(1);
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[w_idx_next];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin : datapath_regs
        if (!RESET_N) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_intr    <= 1'b0;
        end else begin
            r_baud    <= w_baud_next;
            r_bit_idx <= w_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_intr    <= w_intr_next;
        end
    end

    // Strobe edge detect and sticky overflow (set beats clear)
    always_ff @(posedge CLK or negedge RESET_N) begin : port_regs
        if (!RESET_N) begin
            r_strb_d <= 1'b0;
            r_armed  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_strb_d <= IO_STRB;
            r_armed  <= 1'b1;
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_stat_wr) r_ovf <= 1'b0;
        end
    end

    always_comb begin : status_read
        RD_DATA = '0;
        if (PORT_ID == STATUS_ID) begin
            RD_DATA[STAT_OVF]   = r_ovf;
            RD_DATA[STAT_BUSY]  = (r_state != ST_IDLE);
            RD_DATA[STAT_EMPTY] = w_empty;
            RD_DATA[STAT_FULL]  = w_full;
        end
    end

    assign TX   = r_tx;
    assign INTR = r_intr;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx: a queue-based frame model checked every cycle,
// a line decoder, and literal expectations for the key scenarios.
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] RD_DATA;
    logic       TX;
    logic       INTR;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    port_uart_tx #(
        .DATA_ID      (8'h50),
        .STATUS_ID    (8'h51),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .RD_DATA  (RD_DATA),
        .TX       (TX),
        .INTR     (INTR)
    );

    // Model: pending bytes, the frame in flight and its elapsed cycle count
    logic [7:0] m_q[$];
    bit         m_busy;
    int         m_off;
    logic [7:0] m_byte;
    bit         m_ovf;
    bit         m_intr;
    bit         m_strb_prev;
    bit         m_armed;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_off = 0; m_byte = 8'h00; m_ovf = 0;
        m_intr = 0; m_strb_prev = 0; m_armed = 0;
    endtask

    // One clock edge of the model, using the inputs held before the edge
    task automatic model_step();
        bit wr, full_pre, empty_pre, popped, set_ovf;
        wr        = IO_STRB && !m_strb_prev && m_armed;
        full_pre  = (m_q.size() == 4);
        empty_pre = (m_q.size() == 0);
        popped = 0; set_ovf = 0; m_intr = 0;
        if (!m_busy) begin
            if (!empty_pre) begin
                m_byte = m_q.pop_front();
                m_busy = 1; m_off = 0; popped = 1;
            end
        end else if (m_off == FRAME - 1) begin
            m_busy = 0;
            m_intr = empty_pre;
        end else begin
            m_off++;
        end
        if (wr && PORT_ID == 8'h50) begin
            if (!full_pre || popped) m_q.push_back(OUT_PORT);
            else                     set_ovf = 1;
        end
        if (set_ovf)                          m_ovf = 1;
        else if (wr && PORT_ID == 8'h51)      m_ovf = 0;
        m_strb_prev = IO_STRB;
        m_armed = 1;
    endtask

    function automatic logic exp_tx();
        if (!m_busy)         return 1'b1;
        if (m_off < CPB)     return 1'b0;
        if (m_off < 9 * CPB) return m_byte[(m_off - CPB) / CPB];
        return 1'b1;
    endfunction

    function automatic logic [7:0] exp_rd();
        logic [7:0] s;
        s = 8'h00;
        if (PORT_ID == 8'h51) begin
            s[3] = m_ovf;
            s[2] = m_busy;
            s[1] = (m_q.size() == 0);
            s[0] = (m_q.size() == 4);
        end
        return s;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) model_reset();
            else          model_step();
        end
    end

    // Per-cycle compare of every output against the model
    initial begin
        forever begin
            @(negedge CLK);
            chk("tx", 8'(TX), 8'(exp_tx()));
            chk("intr", 8'(INTR), 8'(m_intr));
            chk("rd_data", RD_DATA, exp_rd());
        end
    end

    // Line decoder: samples each bit mid-period after a falling edge
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (prev == 1'b1 && TX == 1'b0) begin
                repeat (CPB + CPB / 2) @(negedge CLK);
                b[0] = TX;
                for (int i = 1; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = TX;
                end
                repeat (CPB) @(negedge CLK);
                rx_q.push_back(b);
            end
            prev = TX;
        end
    end

    task automatic write_port(input logic [7:0] id, input logic [7:0] data);
        @(posedge CLK); #2;
        PORT_ID = id; OUT_PORT = data; IO_STRB = 1'b1;
        @(posedge CLK); #2;
        IO_STRB = 1'b0;
    endtask

    task automatic set_port(input logic [7:0] id);
        @(posedge CLK); #2;
        PORT_ID = id;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while ((m_busy || m_q.size() != 0) && n < budget) begin
            @(posedge CLK); #2;
            n++;
        end
        chk({name, " drained"}, 8'(m_busy || m_q.size() != 0), 8'd0);
        repeat (3) @(posedge CLK);
        #2;
    endtask

    task automatic chk_rx(input string name);
        chk({name, " count"}, 8'(rx_q.size()), 8'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s byte%0d", name, i), rx_q[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        int         lat, n, n_intr, n_low;
        bit         got_low, found;
        logic [9:0] frame_bits;
        logic [3:0] grp;
        logic [7:0] sel;

        // Reset values
        PORT_ID = 8'h51;
        repeat (3) @(negedge CLK);
        chk("reset tx", 8'(TX), 8'd1);
        chk("reset intr", 8'(INTR), 8'd0);
        chk("reset status", RD_DATA, 8'h02);
        @(posedge CLK); #2;
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);

        // Foreign port: no effect, reads zero
        write_port(8'h20, 8'h99);
        @(negedge CLK);
        chk("foreign rd", RD_DATA, 8'h00);
        set_port(8'h51);
        @(negedge CLK);
        chk("foreign status", RD_DATA, 8'h02);

        // A5 frame: latency, exact line waveform, single INTR
        rx_q.delete();
        @(posedge CLK); #2;
        PORT_ID = 8'h50; OUT_PORT = 8'hA5; IO_STRB = 1'b1;
        lat = 0; got_low = 0;
        while (!got_low && lat < 10) begin
            @(posedge CLK); #2;
            IO_STRB = 1'b0;
            lat++;
            @(negedge CLK);
            if (TX == 1'b0) got_low = 1;
        end
        chk("a5 latency", 8'(lat), 8'd2);
        frame_bits = 10'b1101001010;
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 4; k++) begin
                if (j != 0 || k != 0) @(negedge CLK);
                grp[k] = TX;
            end
            chk($sformatf("a5 bit%0d", j), 8'(grp), 8'({4{frame_bits[j]}}));
        end
        n_intr = 0;
        repeat (10) begin
            @(negedge CLK);
            if (INTR) n_intr++;
        end
        chk("a5 intr pulses", 8'(n_intr), 8'd1);
        wait_drained("a5", 200);
        exp_q = '{8'hA5};
        chk_rx("a5 rx");

        // Strobe held high: one byte only
        rx_q.delete();
        @(posedge CLK); #2;
        PORT_ID = 8'h50; OUT_PORT = 8'h3C; IO_STRB = 1'b1;
        repeat (5) @(posedge CLK);
        #2 IO_STRB = 1'b0;
        wait_drained("held", 300);
        exp_q = '{8'h3C};
        chk_rx("held rx");
        set_port(8'h51);
        @(negedge CLK);
        chk("held status", RD_DATA, 8'h02);

        // Six writes: one in flight, four queued, one dropped
        rx_q.delete();
        for (int i = 1; i <= 6; i++) write_port(8'h50, 8'(i));
        set_port(8'h51);
        @(negedge CLK);
        chk("ovf status", RD_DATA, 8'h0D);
        write_port(8'h51, 8'h00);
        @(negedge CLK);
        chk("ovf cleared", RD_DATA, 8'h05);

        // Push into a full FIFO during the inter-frame pop cycle
        n = 0; found = 0;
        while (!found && n < 200) begin
            @(posedge CLK); #2;
            n++;
            if (!m_busy && m_q.size() == 4) found = 1;
        end
        chk("gap found", 8'(found), 8'd1);
        PORT_ID = 8'h50; OUT_PORT = 8'h77; IO_STRB = 1'b1;
        @(posedge CLK); #2;
        IO_STRB = 1'b0; PORT_ID = 8'h51;
        @(negedge CLK);
        chk("push on pop", RD_DATA, 8'h05);
        wait_drained("burst", 2000);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h77};
        chk_rx("burst rx");

        // Reset during data bit 3
        write_port(8'h50, 8'h55);
        n = 0;
        while (!(m_busy && m_off == 4 * CPB + 1) && n < 100) begin
            @(posedge CLK); #2;
            n++;
        end
        chk("pre-reset tx", 8'(TX), 8'd0);
        RESET_N = 1'b0;
        #1;
        chk("reset tx async", 8'(TX), 8'd1);
        chk("reset intr async", 8'(INTR), 8'd0);
        repeat (2) @(posedge CLK);
        #2 RESET_N = 1'b1;
        PORT_ID = 8'h51;
        n_intr = 0; n_low = 0;
        repeat (50) begin
            @(negedge CLK);
            if (INTR) n_intr++;
            if (!TX)  n_low++;
        end
        chk("post-reset intr", 8'(n_intr), 8'd0);
        chk("post-reset tx low", 8'(n_low), 8'd0);
        chk("post-reset status", RD_DATA, 8'h02);
        rx_q.delete();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK); #2;
            IO_STRB  = ($urandom_range(0, 2) == 0);
            OUT_PORT = 8'($urandom);
            sel = 8'($urandom_range(0, 9));
            if (sel < 6)       PORT_ID = 8'h50;
            else if (sel < 8)  PORT_ID = 8'h51;
            else if (sel == 8) PORT_ID = 8'h20;
            else               PORT_ID = 8'($urandom);
        end
        @(posedge CLK); #2;
        IO_STRB = 1'b0;
        PORT_ID = 8'h51;
        wait_drained("random", 2000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_uart_tx.md
PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 Parameter DATA_ID, default 8'h50, port ID whose write pushes a byte into the transmit FIFO.
REQ-002 Parameter STATUS_ID, default 8'h51, port ID for the status read and the overflow clear.
REQ-003 Parameter CLKS_PER_BIT, default 434, number of CLK cycles per serial bit (50 MHz / 115200).
REQ-004 CLK  in  1  single clock; every register is clocked on its rising edge.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 PORT_ID  in  8  port address from the MCU.
REQ-007 OUT_PORT  in  8  MCU write data.
REQ-008 IO_STRB  in  1  MCU write strobe; may stay high for more than one CLK cycle.
REQ-009 RD_DATA  out  8  read data, muxed by the wrapper onto the MCU IN_PORT.
REQ-010 TX  out  1  serial line, 8N1, LSB first, idles high.
REQ-011 INTR  out  1  one-cycle pulse meaning "transmitter drained".

Function
REQ-012 A write SHALL be the first cycle in which IO_STRB is high after a cycle in which it was low (registered edge detect); holding IO_STRB high SHALL produce exactly one write.
REQ-013 A write with PORT_ID==DATA_ID SHALL push OUT_PORT into a 4-entry FIFO.
REQ-014 If the FIFO is full, the push SHALL still be accepted when a pop happens in the same cycle; otherwise the byte is dropped and sticky OVF is set.
REQ-015 A write with PORT_ID==STATUS_ID SHALL clear OVF; if the same cycle also sets OVF, the set wins.
REQ-016 RD_DATA SHALL be combinational: when PORT_ID==STATUS_ID it is {4'b0, OVF, busy, empty, full}, with bit0=full; for any other PORT_ID it is 8'h00.
REQ-017 The transmitter FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-018 In IDLE with the FIFO not empty, the FSM SHALL pop the head byte into the shift register and enter START on the next cycle.
REQ-019 Each state SHALL drive its line level for exactly CLKS_PER_BIT cycles: START drives 0, DATA drives 8 bits LSB first using a 3-bit index, and STOP drives 1.
REQ-020 At the end of STOP, the FSM SHALL go to IDLE; a non-empty FIFO is popped in that IDLE cycle, giving a one-cycle idle gap between frames.
REQ-021 busy SHALL be 1 in any state other than IDLE.
REQ-022 INTR SHALL pulse high for one cycle on the STOP->IDLE transition only if the FIFO is empty at that cycle.
REQ-023 The latency from the write edge to the TX falling edge SHALL be 2 cycles when the FSM is IDLE and the FIFO is empty.
REQ-024 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and be held at 0 in IDLE.

Reset
REQ-025 While RESET_N is low, the block SHALL set: TX=1, INTR=0, FSM=IDLE, FIFO empty with both pointers 0, OVF=0, edge-detect register=0, baud counter=0.
REQ-026 A reset mid-frame SHALL abort the frame immediately, with TX high asynchronously; no partial frame resumes after release.
REQ-027 The first write SHALL be recognised no earlier than the second CLK edge after RESET_N rises.

Structure
REQ-028 Package rat_io_pkg SHALL hold the port ID constants, the FSM state enum, and the status bit positions.
REQ-029 The FIFO SHALL be a sub-module byte_fifo4 (8-bit x 4, push/pop/full/empty, with a 3-bit count).

Verification (CLKS_PER_BIT=4)
REQ-030 Write 8'hA5 to 8'h50 while idle -> TX = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total), followed by a single INTR pulse.
REQ-031 IO_STRB held high for 5 cycles with PORT_ID=8'h50 -> exactly one byte transmitted; status afterwards reads 8'h02.
REQ-032 Six back-to-back writes of 01..06 while idle -> 01..05 transmitted (one popped immediately, four in the FIFO), 06 dropped; status reads 8'h0D mid-frame; a write to 8'h51 clears OVF to give 8'h05.
REQ-033 Push coincident with a pop while full -> byte accepted and no OVF.
REQ-034 RESET_N pulsed low in DATA bit 3 -> TX=1 in the same cycle, status 8'h02, no INTR.
REQ-035 PORT_ID=8'h20 with IO_STRB -> FIFO unchanged and RD_DATA=8'h00.
